// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the Wishbone sequencer that drives i2c_master_top:
// register addresses, CR/SR/CTR bit positions, response error codes,
// sequencer FSM state encodings and a helper that builds CR command bytes.
// ----------------------------------------------------------------------------
package i2c_pkg;

  // i2c_master_top register map (3-bit Wishbone address)
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXRX   = 3'd3;  // TXR on write, RXR on read
  localparam logic [2:0] ADR_CRSR   = 3'd4;  // CR on write, SR on read

  // CR command bits
  localparam int unsigned CR_STA  = 7;
  localparam int unsigned CR_STO  = 6;
  localparam int unsigned CR_RD   = 5;
  localparam int unsigned CR_WR   = 4;
  localparam int unsigned CR_ACK  = 3;
  localparam int unsigned CR_IACK = 0;

  // SR status bits
  localparam int unsigned SR_RXACK = 7;
  localparam int unsigned SR_AL    = 5;
  localparam int unsigned SR_TIP   = 1;

  // CTR core-enable bit and the value written during init
  localparam int unsigned CTR_EN      = 7;
  localparam logic [7:0]  CTR_CORE_EN = 8'h01 << CTR_EN;

  // Response error codes
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_AL      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Sequencer FSM states
  localparam logic [3:0] ST_INIT_PLO = 4'd0;
  localparam logic [3:0] ST_INIT_PHI = 4'd1;
  localparam logic [3:0] ST_INIT_CTR = 4'd2;
  localparam logic [3:0] ST_IDLE     = 4'd3;
  localparam logic [3:0] ST_TX_ADDR  = 4'd4;
  localparam logic [3:0] ST_CR_ADDR  = 4'd5;
  localparam logic [3:0] ST_POLL_A   = 4'd6;
  localparam logic [3:0] ST_TX_DATA  = 4'd7;
  localparam logic [3:0] ST_CR_WR    = 4'd8;
  localparam logic [3:0] ST_CR_RD    = 4'd9;
  localparam logic [3:0] ST_POLL_D   = 4'd10;
  localparam logic [3:0] ST_RD_RXR   = 4'd11;
  localparam logic [3:0] ST_STOP     = 4'd12;
  localparam logic [3:0] ST_DONE     = 4'd13;

  // Assemble a CR command byte from individual command flags
  function automatic logic [7:0] cr_cmd(input logic sta, input logic sto,
                                        input logic rd, input logic wr,
                                        input logic ack, input logic iack);
    logic [7:0] v;
    v          = 8'h00;
    v[CR_STA]  = sta;
    v[CR_STO]  = sto;
    v[CR_RD]   = rd;
    v[CR_WR]   = wr;
    v[CR_ACK]  = ack;
    v[CR_IACK] = iack;
    return v;
  endfunction

endpackage

// File: rtl/i2c_wb_sequencer_if.sv
// ----------------------------------------------------------------------------
// i2c_wb_sequencer_if
// Bundles the command/response handshake and the Wishbone master bus of
// i2c_wb_sequencer.
//   master modport : the sequencer's view (accepts commands, drives the bus)
//   slave modport  : the environment's view (command source, response sink,
//                    and the i2c_master_top Wishbone slave)
// Signals: cmd_valid/cmd_ready/cmd_rw/cmd_addr[6:0]/cmd_wdata[7:0],
//          rsp_valid/rsp_rdata[7:0]/rsp_err[1:0],
//          wbm_adr_o[2:0]/wbm_dat_o[7:0]/wbm_dat_i[7:0]/wbm_we_o/wbm_stb_o/
//          wbm_cyc_o/wbm_ack_i
// ----------------------------------------------------------------------------
interface i2c_wb_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/i2c_wb_access.sv
// ----------------------------------------------------------------------------
// i2c_wb_access
// Single-access Wishbone master engine. A request is accepted when idle;
// adr/dat/we are registered and cyc=stb raised together, all held until ack.
// On the ack edge cyc/stb drop, read data is captured and done pulses for
// one cycle. The done cycle is also a mandatory bus-idle gap in which new
// requests are ignored, so a requester that keeps req high across the done
// cycle cannot trigger a duplicate access.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req/we/adr/wdat     access request
//   done/rdat           completion pulse and captured read data
//   wb_*                Wishbone master signals
// ----------------------------------------------------------------------------
module i2c_wb_access (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic [7:0] rdat,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_BUSY = 2'd1;
  localparam logic [1:0] E_GAP  = 2'd2;

  logic [1:0] st_q,   st_d;
  logic       cyc_q,  cyc_d;
  logic       we_q,   we_d;
  logic [2:0] adr_q,  adr_d;
  logic [7:0] dat_q,  dat_d;
  logic [7:0] rdat_q, rdat_d;
  logic       done_q, done_d;

  // Next-state logic for the access handshake
  always_comb begin
    st_d   = st_q;
    cyc_d  = cyc_q;
    we_d   = we_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    rdat_d = rdat_q;
    done_d = 1'b0;
    case (st_q)
      E_IDLE: begin
        if (req) begin
          cyc_d = 1'b1;
          we_d  = we;
          adr_d = adr;
          dat_d = wdat;
          st_d  = E_BUSY;
        end else begin
          st_d = E_IDLE;
        end
      end
      E_BUSY: begin
        if (wb_ack_i) begin
          cyc_d  = 1'b0;
          rdat_d = wb_dat_i;
          done_d = 1'b1;
          st_d   = E_GAP;
        end else begin
          st_d = E_BUSY;
        end
      end
      E_GAP: begin
        st_d = E_IDLE;
      end
      default: begin
        cyc_d = 1'b0;
        st_d  = E_IDLE;
      end
    endcase
  end

  // Access engine state and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= E_IDLE;
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= 3'd0;
      dat_q  <= 8'h00;
      rdat_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      rdat_q <= rdat_d;
      done_q <= done_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign done     = done_q;
  assign rdat     = rdat_q;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_wb_sequencer
// Wishbone master sitting upstream of i2c_master_top. After each reset it
// writes the prescaler and enables the core once, then turns each accepted
// single-byte I2C command into START+address, data and STOP register
// sequences, polling SR for completion, and returns one response per command.
// Parameters:
//   PRESCALE    value for PRERhi:PRERlo
//   POLL_LIMIT  maximum SR reads per poll phase before a timeout error
// Ports:
//   wb_clk_i    clock shared with i2c_master_top
//   arst_i      asynchronous reset, active-low
//   bus         i2c_wb_sequencer_if.master (command, response, Wishbone)
// ----------------------------------------------------------------------------
module i2c_wb_sequencer
  import i2c_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'h0009,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input logic                 wb_clk_i,
  input logic                 arst_i,
  i2c_wb_sequencer_if.master  bus
);

  logic [3:0]  state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic        rw_q,        rw_d;
  logic [6:0]  addr_q,      addr_d;
  logic [7:0]  wdata_q,     wdata_d;
  logic [1:0]  err_q,       err_d;
  logic [7:0]  rdata_q,     rdata_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_err_q,   rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  logic [15:0] cnt_inc;
  logic        poll_entry;
  logic        acc_req;
  logic        acc_we;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_wdat;
  logic        acc_done;
  logic [7:0]  acc_rdat;

  i2c_wb_access u_access (
    .clk      (wb_clk_i),
    .rst_n    (arst_i),
    .req      (acc_req),
    .we       (acc_we),
    .adr      (acc_adr),
    .wdat     (acc_wdat),
    .done     (acc_done),
    .rdat     (acc_rdat),
    .wb_adr_o (bus.wbm_adr_o),
    .wb_dat_o (bus.wbm_dat_o),
    .wb_we_o  (bus.wbm_we_o),
    .wb_stb_o (bus.wbm_stb_o),
    .wb_cyc_o (bus.wbm_cyc_o),
    .wb_dat_i (bus.wbm_dat_i),
    .wb_ack_i (bus.wbm_ack_i)
  );

  // Sequencer FSM: each state issues at most one register access and
  // advances when the access engine reports completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    acc_req     = 1'b0;
    acc_we      = 1'b1;
    acc_adr     = ADR_CRSR;
    acc_wdat    = 8'h00;
    // saturating SR-read count; never wraps back to zero
    cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    case (state_q)
      ST_INIT_PLO: begin
        acc_req  = 1'b1;
        acc_adr  = ADR_PRERLO;
        acc_wdat = PRESCALE[7:0];
        if (acc_done) state_d = ST_INIT_PHI; else state_d = state_q;
      end
      ST_INIT_PHI: begin
        acc_req  = 1'b1;
        acc_adr  = ADR_PRERHI;
        acc_wdat = PRESCALE[15:8];
        if (acc_done) state_d = ST_INIT_CTR; else state_d = state_q;
      end
      ST_INIT_CTR: begin
        acc_req  = 1'b1;
        acc_adr  = ADR_CTR;
        acc_wdat = CTR_CORE_EN;
        if (acc_done) state_d = ST_IDLE; else state_d = state_q;
      end
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          rw_d    = bus.cmd_rw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          err_d   = ERR_OK;
          rdata_d = 8'h00;
          state_d = ST_TX_ADDR;
        end else begin
          state_d = state_q;
        end
      end
      ST_TX_ADDR: begin
        acc_req  = 1'b1;
        acc_adr  = ADR_TXRX;
        acc_wdat = {addr_q, rw_q};
        if (acc_done) state_d = ST_CR_ADDR; else state_d = state_q;
      end
      ST_CR_ADDR: begin
        acc_req  = 1'b1;
        acc_wdat = cr_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (acc_done) state_d = ST_POLL_A; else state_d = state_q;
      end
      ST_POLL_A: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        if (acc_done) begin
          cnt_d = cnt_inc;
          if (!acc_rdat[SR_TIP]) begin
            if (acc_rdat[SR_AL]) begin
              err_d   = ERR_AL;
              state_d = ST_DONE;
            end else if (acc_rdat[SR_RXACK]) begin
              err_d   = ERR_NACK;
              state_d = ST_STOP;
            end else if (rw_q) begin
              state_d = ST_CR_RD;
            end else begin
              state_d = ST_TX_DATA;
            end
          end else if (cnt_inc >= POLL_LIMIT) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_STOP;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_TX_DATA: begin
        acc_req  = 1'b1;
        acc_adr  = ADR_TXRX;
        acc_wdat = wdata_q;
        if (acc_done) state_d = ST_CR_WR; else state_d = state_q;
      end
      ST_CR_WR: begin
        acc_req  = 1'b1;
        acc_wdat = cr_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if (acc_done) state_d = ST_POLL_D; else state_d = state_q;
      end
      ST_CR_RD: begin
        // ACK bit set = master NACKs the single byte, with STOP
        acc_req  = 1'b1;
        acc_wdat = cr_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        if (acc_done) state_d = ST_POLL_D; else state_d = state_q;
      end
      ST_POLL_D: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        if (acc_done) begin
          cnt_d = cnt_inc;
          if (!acc_rdat[SR_TIP]) begin
            if (acc_rdat[SR_AL]) begin
              err_d   = ERR_AL;
              state_d = ST_DONE;
            end else if (rw_q) begin
              state_d = ST_RD_RXR;
            end else if (acc_rdat[SR_RXACK]) begin
              // STO was already part of the data command
              err_d   = ERR_NACK;
              state_d = ST_DONE;
            end else begin
              state_d = ST_DONE;
            end
          end else if (cnt_inc >= POLL_LIMIT) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_STOP;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_RXR: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        acc_adr = ADR_TXRX;
        if (acc_done) begin
          rdata_d = acc_rdat;
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_STOP: begin
        acc_req  = 1'b1;
        acc_wdat = cr_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (acc_done) state_d = ST_DONE; else state_d = state_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT_PLO;
      end
    endcase

    // every fresh entry into a poll phase restarts the SR-read count
    poll_entry = (state_d != state_q) &&
                 ((state_d == ST_POLL_A) || (state_d == ST_POLL_D));
    if (poll_entry) begin
      cnt_d = 16'h0000;
    end else begin
      cnt_d = cnt_d;
    end

    // response fields update only on entry to DONE and hold afterwards
    rsp_valid_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    if (rsp_valid_d) begin
      rsp_err_d   = err_d;
      rsp_rdata_d = rdata_d;
    end else begin
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Sequencer state and registered command/response outputs
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= ST_INIT_PLO;
      cnt_q       <= 16'h0000;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      wdata_q     <= 8'h00;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
